// File: rtl/laser_scheduler.sv
// Per-frame round of tower laser grants in index order; muxes the granted laser onto the
// VGA write port and ORs kill reports. Optional grant watchdog: define LASER_SCHED_WDOG_EN.
module laser_scheduler #(
  parameter int unsigned N_LASERS = 4,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_tick,
  input  logic [N_LASERS-1:0]   tower_placed,
  input  logic [N_LASERS-1:0]   laser_done,
  input  logic [N_LASERS-1:0]   laser_we,
  input  logic [15*N_LASERS-1:0] laser_coords,
  input  logic [9*N_LASERS-1:0] laser_colour,
  input  logic [4*N_LASERS-1:0] laser_destroyed,
  output logic [N_LASERS-1:0]   enable_draw,
  output logic                  vga_WriteEn,
  output logic [14:0]           vga_coords,
  output logic [8:0]            vga_colour,
  output logic [3:0]            destroyed_cars,
  output logic                  busy,
  output logic                  cycle_done,
  output logic                  timeout_err
);

  localparam int unsigned SEL_W  = (N_LASERS > 1) ? $clog2(N_LASERS) : 1;
  localparam int unsigned PTR_W  = $clog2(N_LASERS + 1);
  localparam int unsigned XY_W   = 15;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned KILL_W = 4;

  if (N_LASERS < 1 || N_LASERS > 8 || TIMEOUT < 2) begin : g_param_check
    $error("laser_scheduler: unsupported N_LASERS or TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

  state_t              state;
  state_t              next_state;
  logic [N_LASERS-1:0] mask;
  logic [PTR_W-1:0]    ptr;
  logic [SEL_W-1:0]    sel;
  logic                pending;

  logic                found_c;
  logic [SEL_W-1:0]    found_idx_c;
  logic [N_LASERS-1:0] grant_vec_c;
  logic                sel_done_c;
  logic                sel_we_c;
  logic [XY_W-1:0]     sel_coords_c;
  logic [COL_W-1:0]    sel_colour_c;
  logic [KILL_W-1:0]   sel_kill_c;
  logic                start_c;
  logic                grant_c;
  logic                finish_c;
  logic                release_c;
  logic                wdog_expire_c;

  // Lowest placed laser at or above ptr
  always_comb begin
    found_c     = 1'b0;
    found_idx_c = '0;
    grant_vec_c = '0;
    for (int i = 0; i < int'(N_LASERS); i++) begin
      if (!found_c && mask[i] && (32'(i) >= 32'(ptr))) begin
        found_c        = 1'b1;
        found_idx_c    = SEL_W'(i);
        grant_vec_c[i] = 1'b1;
      end
    end
  end

  // Mux of the currently selected laser's signals
  always_comb begin
    sel_done_c   = 1'b0;
    sel_we_c     = 1'b0;
    sel_coords_c = '0;
    sel_colour_c = '0;
    sel_kill_c   = '0;
    for (int i = 0; i < int'(N_LASERS); i++) begin
      if (SEL_W'(i) == sel) begin
        sel_done_c   = laser_done[i];
        sel_we_c     = laser_we[i];
        sel_coords_c = laser_coords[XY_W*i +: XY_W];
        sel_colour_c = laser_colour[COL_W*i +: COL_W];
        sel_kill_c   = laser_destroyed[KILL_W*i +: KILL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_c    = 1'b0;
    grant_c    = 1'b0;
    finish_c   = 1'b0;
    release_c  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick || pending) begin
          start_c    = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (found_c) begin
          grant_c    = 1'b1;
          next_state = WAIT;
        end else begin
          next_state = DONE;
        end
      end
      WAIT: begin
        if (sel_done_c) begin
          finish_c   = 1'b1;
          release_c  = 1'b1;
          next_state = SCAN;
        end else if (wdog_expire_c) begin
          release_c  = 1'b1;
          next_state = SCAN;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      mask           <= '0;
      ptr            <= '0;
      sel            <= '0;
      pending        <= 1'b0;
      enable_draw    <= '0;
      vga_WriteEn    <= 1'b0;
      vga_coords     <= '0;
      vga_colour     <= '0;
      destroyed_cars <= '0;
      busy           <= 1'b0;
      cycle_done     <= 1'b0;
    end else begin
      // One-deep memory of a tick that arrives while a round is in progress
      if (start_c)                         pending <= 1'b0;
      else if (frame_tick && state != IDLE) pending <= 1'b1;

      if (start_c) begin
        mask           <= tower_placed;
        ptr            <= '0;
        destroyed_cars <= '0;
        busy           <= 1'b1;
      end

      if (grant_c) begin
        sel         <= found_idx_c;
        enable_draw <= grant_vec_c;
      end

      if (state == WAIT) begin
        vga_WriteEn <= sel_we_c;
        vga_coords  <= sel_coords_c;
        vga_colour  <= sel_colour_c;
      end else begin
        vga_WriteEn <= 1'b0;
      end

      if (release_c) begin
        enable_draw <= '0;
        ptr         <= PTR_W'(sel) + PTR_W'(1);
      end
      if (finish_c) destroyed_cars <= destroyed_cars | sel_kill_c;

      if (state == DONE) busy <= 1'b0;
      cycle_done <= (next_state == DONE);
    end
  end

`ifdef LASER_SCHED_WDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] wdog_cnt;

  assign wdog_expire_c = (state == WAIT) && !sel_done_c && (wdog_cnt == CNT_W'(TIMEOUT - 1));

  // Per-grant cycle counter; a stuck laser is skipped and flagged
  always_ff @(posedge clk) begin
    if (resetn) begin
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant_c)             wdog_cnt <= '0;
      else if (state == WAIT)  wdog_cnt <= wdog_cnt + CNT_W'(1);
      if (wdog_expire_c)       timeout_err <= 1'b1;
    end
  end
`else
  assign wdog_expire_c = 1'b0;
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_laser_scheduler.sv
// Directed bench for laser_scheduler with a small behavioural laser model per tower.
module tb_laser_scheduler;

  localparam int unsigned N = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            frame_tick;
  logic [N-1:0]    tower_placed;
  logic [N-1:0]    laser_done;
  logic [N-1:0]    laser_we;
  logic [15*N-1:0] laser_coords;
  logic [9*N-1:0]  laser_colour;
  logic [4*N-1:0]  laser_destroyed;
  logic [N-1:0]    enable_draw;
  logic            vga_WriteEn;
  logic [14:0]     vga_coords;
  logic [8:0]      vga_colour;
  logic [3:0]      destroyed_cars;
  logic            busy;
  logic            cycle_done;
  logic            timeout_err;

  int          run_len [N];
  int          wcnt    [N];
  logic [14:0] crd     [N];
  logic [8:0]  col     [N];
  logic [3:0]  kill    [N];
  logic [N-1:0] we_drv;

  int n_total = 0;
  int n_bad   = 0;

  laser_scheduler #(.N_LASERS(N), .TIMEOUT(16)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .frame_tick      (frame_tick),
    .tower_placed    (tower_placed),
    .laser_done      (laser_done),
    .laser_we        (laser_we),
    .laser_coords    (laser_coords),
    .laser_colour    (laser_colour),
    .laser_destroyed (laser_destroyed),
    .enable_draw     (enable_draw),
    .vga_WriteEn     (vga_WriteEn),
    .vga_coords      (vga_coords),
    .vga_colour      (vga_colour),
    .destroyed_cars  (destroyed_cars),
    .busy            (busy),
    .cycle_done      (cycle_done),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  // Laser model: done after run_len granted cycles (0 = never)
  always @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) wcnt[i] <= enable_draw[i] ? wcnt[i] + 1 : 0;
  end

  always_comb begin
    laser_done      = '0;
    laser_coords    = '0;
    laser_colour    = '0;
    laser_destroyed = '0;
    for (int i = 0; i < int'(N); i++) begin
      laser_done[i]           = enable_draw[i] && (run_len[i] != 0) && (wcnt[i] == run_len[i] - 1);
      laser_coords[15*i +: 15] = crd[i];
      laser_colour[9*i +: 9]   = col[i];
      laser_destroyed[4*i +: 4] = kill[i];
    end
  end

  assign laser_we = we_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the first busy cycle
  task automatic pulse_frame();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Observe one round until cycle_done; returns at the negedge where cycle_done is high
  task automatic run_cycle(output int bcyc, output int ngr, output logic [3:0] g0,
                           output logic [3:0] g1, output int multi, output int en0,
                           output logic seen, output logic [3:0] kills);
    logic [3:0] prev;
    bcyc = 0; ngr = 0; g0 = '0; g1 = '0; multi = 0; en0 = 0; seen = 1'b0; kills = '0;
    prev = '0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (busy) bcyc++;
      if ($countones(enable_draw) > 1) multi++;
      if (enable_draw[0]) en0++;
      if (enable_draw != prev && enable_draw != '0) begin
        if (ngr == 0)      g0 = enable_draw;
        else if (ngr == 1) g1 = enable_draw;
        ngr++;
      end
      prev = enable_draw;
      if (cycle_done) begin
        seen  = 1'b1;
        kills = destroyed_cars;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bcyc, ngr, multi, en0, ndone, gap, first_done, second_done, late_done;
    logic [3:0] g0, g1, kills;
    logic seen;

    resetn       = 1'b1;
    frame_tick   = 1'b0;
    tower_placed = '0;
    we_drv       = '0;
    for (int i = 0; i < int'(N); i++) begin
      run_len[i] = 0;
      crd[i]     = '0;
      col[i]     = '0;
    end
    kill[0] = 4'b0001; kill[1] = 4'b0010; kill[2] = 4'b0100; kill[3] = 4'b1000;

    step(3);
    check("rst_enable", 32'(enable_draw), 32'h0);
    check("rst_flags", {28'h0, busy, cycle_done, vga_WriteEn, timeout_err}, 32'h0);
    check("rst_vga", {8'h0, vga_coords, vga_colour}, 32'h0);
    check("rst_kills", 32'(destroyed_cars), 32'h0);
    resetn = 1'b0;
    step(2);

    // Empty mask: busy for two cycles, cycle_done on the second
    tower_placed = 4'b0000;
    pulse_frame();
    check("empty_c1", {30'h0, busy, cycle_done}, 32'b10);
    step(1);
    check("empty_c2", {30'h0, busy, cycle_done}, 32'b11);
    check("empty_enable", 32'(enable_draw), 32'h0);
    step(1);
    check("empty_c3", {30'h0, busy, cycle_done}, 32'b00);
    check("empty_kills", 32'(destroyed_cars), 32'h0);
    step(2);

    // Sequencing: towers 1 and 3, five cycles each
    tower_placed = 4'b1010;
    for (int i = 0; i < int'(N); i++) run_len[i] = 5;
    pulse_frame();
    tower_placed = 4'b1111;
    run_cycle(bcyc, ngr, g0, g1, multi, en0, seen, kills);
    check("seq_done_seen", 32'(seen), 32'h1);
    check("seq_busy_cycles", 32'(bcyc), 32'd14);
    check("seq_grant_count", 32'(ngr), 32'd2);
    check("seq_grant0", 32'(g0), 32'b0010);
    check("seq_grant1", 32'(g1), 32'b1000);
    check("seq_onehot", 32'(multi), 32'd0);
    check("seq_kills", 32'(kills), 32'b1010);
    step(3);

    // Kills and immediate done: laser 0 done on its first granted cycle
    tower_placed = 4'b0101;
    run_len[0] = 1;
    run_len[2] = 3;
    pulse_frame();
    run_cycle(bcyc, ngr, g0, g1, multi, en0, seen, kills);
    check("kill_done_seen", 32'(seen), 32'h1);
    check("kill_busy_cycles", 32'(bcyc), 32'd8);
    check("kill_grant0_len", 32'(en0), 32'd1);
    check("kill_grants", {24'h0, g1, g0}, {24'h0, 4'b0100, 4'b0001});
    check("kill_mask", 32'(kills), 32'b0101);
    step(3);
    check("kill_hold", {27'h0, busy, destroyed_cars}, {27'h0, 1'b0, 4'b0101});
    tower_placed = 4'b0000;
    pulse_frame();
    check("kill_clear", 32'(destroyed_cars), 32'h0);
    step(3);

    // VGA routing: only the granted laser reaches the write port
    tower_placed = 4'b0010;
    run_len[1] = 3;
    we_drv = 4'b1010;
    crd[1] = 15'h1234; col[1] = 9'h1FF;
    crd[3] = 15'h7ABC; col[3] = 9'h055;
    pulse_frame();
    check("vga_scan_we", 32'(vga_WriteEn), 32'h0);
    step(1);
    check("vga_w0", {27'h0, enable_draw, vga_WriteEn}, {27'h0, 4'b0010, 1'b0});
    step(1);
    check("vga_w1", {7'h0, vga_WriteEn, vga_coords, vga_colour}, {7'h0, 1'b1, 15'h1234, 9'h1FF});
    step(2);
    check("vga_done_beat", {27'h0, enable_draw, vga_WriteEn}, {27'h0, 4'b0000, 1'b1});
    step(1);
    check("vga_idle", {7'h0, vga_WriteEn, vga_coords, vga_colour}, {7'h0, 1'b0, 15'h1234, 9'h1FF});
    check("vga_cycle_done", {27'h0, cycle_done, destroyed_cars}, {27'h0, 1'b1, 4'b0010});
    we_drv = '0;
    step(3);

    // Pending tick: two extra ticks during a busy round give exactly one more round
    tower_placed = 4'b0001;
    run_len[0] = 4;
    ndone = 0; gap = 0; first_done = 0; second_done = 0;
    for (int j = 0; j < 40; j++) begin
      if (cycle_done) begin
        ndone++;
        if (ndone == 1) first_done = j;
        else if (ndone == 2) second_done = j;
      end else if (!busy && ndone == 1) begin
        gap++;
      end
      frame_tick = (j == 0 || j == 2 || j == 4);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    check("pend_done_count", 32'(ndone), 32'd2);
    check("pend_first_done", 32'(first_done), 32'd7);
    check("pend_idle_gap", 32'(gap), 32'd1);
    check("pend_spacing", 32'(second_done - first_done), 32'd8);

    // Reset mid-round drops the grant and produces no cycle_done
    run_len[0] = 0;
    pulse_frame();
    step(2);
    check("mid_grant", {27'h0, busy, enable_draw}, {27'h0, 1'b1, 4'b0001});
    resetn = 1'b1;
    step(1);
    check("mid_reset", {27'h0, busy, enable_draw}, {27'h0, 1'b0, 4'b0000});
    check("mid_reset_kills", 32'(destroyed_cars), 32'h0);
    resetn = 1'b0;
    late_done = 0;
    for (int j = 0; j < 10; j++) begin
      if (cycle_done || busy) late_done++;
      @(negedge clk);
    end
    check("mid_no_done", 32'(late_done), 32'd0);

`ifdef LASER_SCHED_WDOG_EN
    // Watchdog: laser 0 never finishes, laser 1 still gets its turn
    tower_placed = 4'b0011;
    run_len[0] = 0;
    run_len[1] = 2;
    pulse_frame();
    run_cycle(bcyc, ngr, g0, g1, multi, en0, seen, kills);
    check("wdog_done_seen", 32'(seen), 32'h1);
    check("wdog_grant0_len", 32'(en0), 32'd16);
    check("wdog_grants", {24'h0, g1, g0}, {24'h0, 4'b0010, 4'b0001});
    check("wdog_kills", 32'(kills), 32'b0010);
    check("wdog_busy_cycles", 32'(bcyc), 32'd22);
    check("wdog_err_set", 32'(timeout_err), 32'h1);
    step(2);
    resetn = 1'b1;
    step(1);
    resetn = 1'b0;
`endif
    check("timeout_err_clear", 32'(timeout_err), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
